// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, RGB565 colours and coordinate type
package vga_pkg;
  localparam int H_VALID = 640;
  localparam int V_VALID = 480;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/blk_bounce_axis.sv
// blk_bounce_axis: one axis of the bouncing square, position plus travel direction
module blk_bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 600,
  parameter int STEP  = 2
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       move,
  output logic [9:0] pos,
  output logic       dir
);
  coord_t pos_d, pos_q;
  logic dir_d, dir_q;
  logic [10:0] pos_up;
  // bounce rule: clamp to the wall and reverse when the next step would reach or pass it
  always_comb begin
    pos_up = {1'b0, pos_q} + 11'(STEP);
    pos_d = pos_q;
    dir_d = dir_q;
    if (move) begin
      if (dir_q) begin
        pos_d = (pos_up >= 11'(LIMIT)) ? 10'(LIMIT) : pos_q + 10'(STEP);
        dir_d = (pos_up >= 11'(LIMIT)) ? 1'b0 : 1'b1;
      end else begin
        pos_d = ({1'b0, pos_q} <= 11'(STEP)) ? 10'd0 : pos_q - 10'(STEP);
        dir_d = ({1'b0, pos_q} <= 11'(STEP)) ? 1'b1 : 1'b0;
      end
    end
  end
  // position/direction registers; reset parks the square top-left heading right/down
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pos_q <= '0;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end
  assign pos = pos_q;
  assign dir = dir_q;
endmodule

// File: rtl/vga_bounce_pic.sv
// vga_bounce_pic: renders a solid square bouncing around the active area, moved once per frame
module vga_bounce_pic
  import vga_pkg::*;
#(
  parameter int          H_VALID   = vga_pkg::H_VALID,
  parameter int          V_VALID   = vga_pkg::V_VALID,
  parameter int          BLK_SIZE  = 40,
  parameter int          STEP      = 2,
  parameter int          FRAME_DIV = 1,
  parameter logic [15:0] BG_COLOR  = WHITE,
  parameter logic [15:0] BLK_COLOR = BLUE
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pause,
  output logic [15:0] pix_data,
  output logic        frame_tick,
  output logic [9:0]  blk_x,
  output logic [9:0]  blk_y
);
  localparam int CW = $clog2(FRAME_DIV + 1);
  logic fe, last, move, in_blk;
  logic [CW-1:0] frame_cnt_d, frame_cnt_q;
  logic [15:0] pix_data_d, pix_data_q;
  logic frame_tick_q;
  logic [10:0] x11, y11, bx11, by11;
  logic dir_x, dir_y;
  // frame-end detect, frame divider and move qualifier; the move lands after the last
  // active pixel so every frame shows one consistent square
  always_comb begin
    fe = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    last = (frame_cnt_q == CW'(FRAME_DIV - 1));
    frame_cnt_d = fe ? (last ? '0 : frame_cnt_q + CW'(1)) : frame_cnt_q;
    move = fe && last && !pause;
  end
  // pixel mux; 11-bit compares keep blk+BLK_SIZE from wrapping
  always_comb begin
    x11 = {1'b0, pix_x};
    y11 = {1'b0, pix_y};
    bx11 = {1'b0, blk_x};
    by11 = {1'b0, blk_y};
    in_blk = (x11 >= bx11) && (x11 < bx11 + 11'(BLK_SIZE)) &&
             (y11 >= by11) && (y11 < by11 + 11'(BLK_SIZE));
    pix_data_d = in_blk ? BLK_COLOR :
                 ((x11 < 11'(H_VALID)) && (y11 < 11'(V_VALID))) ? BG_COLOR : BLACK;
  end
  // output and frame-counter registers
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data_q <= '0;
      frame_tick_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      pix_data_q <= pix_data_d;
      frame_tick_q <= fe;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  blk_bounce_axis #(.LIMIT(H_VALID - BLK_SIZE), .STEP(STEP)) u_axis_x (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .move(move), .pos(blk_x), .dir(dir_x)
  );
  blk_bounce_axis #(.LIMIT(V_VALID - BLK_SIZE), .STEP(STEP)) u_axis_y (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .move(move), .pos(blk_y), .dir(dir_y)
  );
  assign pix_data = pix_data_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_bounce_pic.sv
// tb_vga_bounce_pic: directed scoreboard bench for the bouncing-square pixel source
module tb_vga_bounce_pic;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] px = '1, py = '1, px2 = '1, py2 = '1;
  logic pause = 1'b0;
  logic [15:0] pix_data, pix_data2;
  logic frame_tick, frame_tick2;
  logic [9:0] blk_x, blk_y, blk_x2, blk_y2;
  int checks = 0, failures = 0;
  logic [15:0] sb[$];
  int mx, my, mdx, mdy;
  int nx, ny, ndx, ndy, fcnt2;
  always #5 clk = ~clk;
  vga_bounce_pic dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(px), .pix_y(py), .pause(pause),
    .pix_data(pix_data), .frame_tick(frame_tick), .blk_x(blk_x), .blk_y(blk_y)
  );
  vga_bounce_pic #(.H_VALID(480), .V_VALID(480), .FRAME_DIV(3)) dut2 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(px2), .pix_y(py2), .pause(1'b0),
    .pix_data(pix_data2), .frame_tick(frame_tick2), .blk_x(blk_x2), .blk_y(blk_y2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] exp_pix(input int x, input int y, input int bx, input int by);
    if (x >= bx && x < bx + 40 && y >= by && y < by + 40) return 16'h001F;
    if (x < 640 && y < 480) return 16'hFFFF;
    return 16'h0000;
  endfunction
  task automatic axis(inout int p, inout int d, input int lim);
    if (d == 1) begin
      if (p + 2 >= lim) begin p = lim; d = 0; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1; end
      else p = p - 2;
    end
  endtask
  task automatic step(input logic [9:0] x, input logic [9:0] y);
    logic fe;
    @(negedge clk);
    px = x; py = y; px2 = '1; py2 = '1;
    fe = (x == 10'd639) && (y == 10'd479);
    sb.push_back(exp_pix(int'(x), int'(y), mx, my));
    if (fe && !pause) begin
      axis(mx, mdx, 600);
      axis(my, mdy, 440);
    end
    @(posedge clk); #1;
    chk("pix_data", pix_data, sb.pop_front());
    chk("frame_tick", frame_tick, fe);
    chk("blk_x", blk_x, mx);
    chk("blk_y", blk_y, my);
    chk("pix_data2_idle", pix_data2, 16'h0000);
  endtask
  task automatic step2(input logic [9:0] x, input logic [9:0] y);
    logic fe;
    @(negedge clk);
    px2 = x; py2 = y; px = '1; py = '1;
    fe = (x == 10'd479) && (y == 10'd479);
    if (fe) begin
      if (fcnt2 == 2) begin
        fcnt2 = 0;
        axis(nx, ndx, 440);
        axis(ny, ndy, 440);
      end else fcnt2++;
    end
    @(posedge clk); #1;
    chk("frame_tick2", frame_tick2, fe);
    chk("blk_x2", blk_x2, nx);
    chk("blk_y2", blk_y2, ny);
  endtask
  task automatic model_reset();
    mx = 0; my = 0; mdx = 1; mdy = 1;
    nx = 0; ny = 0; ndx = 1; ndy = 1; fcnt2 = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_data", pix_data, 16'h0000);
    chk("rst_frame_tick", frame_tick, 1'b0);
    chk("rst_blk_x", blk_x, 10'd0);
    chk("rst_blk_y", blk_y, 10'd0);
    chk("rst_blk_x2", blk_x2, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(10'd0, 10'd0);
    step(10'd40, 10'd0);
    step(10'h3FF, 10'h3FF);
    step(10'd39, 10'd39);
    step(10'd0, 10'd40);
    step(10'd639, 10'd479);
    step(10'h3FF, 10'h3FF);
    chk("first_move_x", blk_x, 10'd2);
    chk("first_move_y", blk_y, 10'd2);
    step(10'd0, 10'd0);
    step(10'd2, 10'd2);
    step(10'd41, 10'd41);
    step(10'd42, 10'd2);
    while (mx < 598) begin
      step(10'd639, 10'd479);
      step(10'h3FF, 10'h3FF);
    end
    chk("x_before_wall", blk_x, 10'd598);
    step(10'd639, 10'd479);
    chk("x_at_wall", blk_x, 10'd600);
    step(10'd639, 10'd479);
    chk("x_after_bounce", blk_x, 10'd598);
    step(10'd639, 10'd479);
    step(10'd598, 10'd300);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(10'd639, 10'd479);
      step(10'h3FF, 10'h3FF);
    end
    chk("pause_hold_x", blk_x, 10'd596);
    pause = 1'b0;
    step(10'd639, 10'd479);
    chk("resume_x", blk_x, 10'd594);
    for (int i = 0; i < 1323; i++) begin
      step2(10'd479, 10'd479);
      step2(10'h3FF, 10'h3FF);
      if (i == 659) begin
        chk("corner_x2", blk_x2, 10'd440);
        chk("corner_y2", blk_y2, 10'd440);
      end
    end
    chk("zero_bounce_x2", blk_x2, 10'd2);
    step(blk_x, blk_y);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_pix_data", pix_data, 16'h0000);
    chk("async_blk_x", blk_x, 10'd0);
    chk("async_blk_y", blk_y, 10'd0);
    chk("async_blk_y2", blk_y2, 10'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(10'd0, 10'd0);
    step(10'd639, 10'd479);
    step(10'd1, 10'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
